// File: rtl/clz_arbiter_pkg.sv
// Shared constants and width helpers for the CLZ arbiter slice.
package clz_pkg;

    // Default operand width used when no override is supplied.
    localparam int CLZ_WIDTH = 32;

    // Width of a leading-zero count able to represent 0..width inclusive.
    function automatic int cnt_w(input int width);
        return $clog2(width) + 1;
    endfunction

    // Width of a requester index; never narrower than one bit.
    function automatic int id_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/clz_arbiter_if.sv
// Request/result bundle between requesters, the arbiter and the downstream consumer.
interface clz_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = clz_pkg::CLZ_WIDTH
);
    import clz_pkg::*;

    localparam int CW = cnt_w(WIDTH);
    localparam int IW = id_w(NUM_REQ);

    logic [NUM_REQ-1:0]       i_REQ_VALID;
    logic [NUM_REQ*WIDTH-1:0] i_REQ_WORD;
    logic [NUM_REQ-1:0]       o_REQ_READY;
    logic                     o_RES_VALID;
    logic [CW-1:0]            o_RES_COUNT;
    logic                     o_RES_ZERO;
    logic [IW-1:0]            o_RES_ID;
    logic                     i_RES_READY;

    // Arbiter side.
    modport slave (
        input  i_REQ_VALID,
        input  i_REQ_WORD,
        input  i_RES_READY,
        output o_REQ_READY,
        output o_RES_VALID,
        output o_RES_COUNT,
        output o_RES_ZERO,
        output o_RES_ID
    );

    // Requester / consumer side.
    modport master (
        output i_REQ_VALID,
        output i_REQ_WORD,
        output i_RES_READY,
        input  o_REQ_READY,
        input  o_RES_VALID,
        input  o_RES_COUNT,
        input  o_RES_ZERO,
        input  o_RES_ID
    );

endinterface

// File: rtl/clz_arbiter_clz.sv
// Combinational count-leading-zeros for one WIDTH-bit operand.
module count_leading_zeros
    import clz_pkg::*;
#(
    parameter int WIDTH = CLZ_WIDTH
) (
    input  logic [WIDTH-1:0]        i_word,
    output logic [cnt_w(WIDTH)-1:0] o_count,
    output logic                    o_zero
);

    localparam int CW = cnt_w(WIDTH);

    // Scan upward so the highest set bit is the last one to write the count.
    always_comb begin
        o_count = CW'(WIDTH);
        o_zero  = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            if (i_word[i]) begin
                o_count = CW'(WIDTH - 1 - i);
                o_zero  = 1'b0;
            end
        end
    end

endmodule

// File: rtl/clz_arbiter.sv
// Round-robin arbiter sharing one CLZ datapath among NUM_REQ requesters,
// with a single registered, ID-tagged result stage honouring backpressure.
module clz_arbiter
    import clz_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = CLZ_WIDTH
) (
    input  logic          i_CLK,
    input  logic          i_RST_N,
    clz_arbiter_if.slave  bus
);

    localparam int CW = cnt_w(WIDTH);
    localparam int IW = id_w(NUM_REQ);

    // Round-robin pointer: index of the requester with highest priority.
    logic [IW-1:0]          ptr_q, ptr_d;

    // Result register.
    logic                   res_valid_q, res_valid_d;
    logic [CW-1:0]          res_count_q, res_count_d;
    logic                   res_zero_q,  res_zero_d;
    logic [IW-1:0]          res_id_q,    res_id_d;

    // Arbitration signals.
    logic [2*NUM_REQ-1:0]   req_dbl;
    logic [2*NUM_REQ-1:0]   mask_dbl;
    logic [2*NUM_REQ-1:0]   cand_dbl;
    logic                   gnt_any;
    logic [IW-1:0]          gnt_idx;
    logic                   can_accept;
    logic [NUM_REQ-1:0]     req_ready;
    logic                   xfer;

    // Datapath signals.
    logic [WIDTH-1:0]       word_sel;
    logic [CW-1:0]          clz_count;
    logic                   clz_zero;

    // Double-width masked priority search: lower copy masked below the
    // pointer, upper copy unmasked, so the first hit wraps naturally.
    always_comb begin
        req_dbl  = {bus.i_REQ_VALID, bus.i_REQ_VALID};
        mask_dbl = '0;
        for (int i = 0; i < 2*NUM_REQ; i++) begin
            mask_dbl[i] = (i >= int'(ptr_q));
        end
        cand_dbl = req_dbl & mask_dbl;
        gnt_any  = 1'b0;
        gnt_idx  = '0;
        for (int i = 2*NUM_REQ-1; i >= 0; i--) begin
            if (cand_dbl[i]) begin
                gnt_any = 1'b1;
                gnt_idx = IW'((i >= NUM_REQ) ? (i - NUM_REQ) : i);
            end
        end
    end

    // The result slot is free when empty or being drained this cycle.
    assign can_accept = !res_valid_q || bus.i_RES_READY;

    // One-hot grant, suppressed while reset is asserted or the slot is busy.
    always_comb begin
        req_ready = '0;
        if (i_RST_N && can_accept && gnt_any) begin
            req_ready[gnt_idx] = 1'b1;
        end
    end

    assign xfer            = |(bus.i_REQ_VALID & req_ready);
    assign bus.o_REQ_READY = req_ready;

    // Route the granted operand into the shared CLZ.
    assign word_sel = bus.i_REQ_WORD[gnt_idx*WIDTH +: WIDTH];

    count_leading_zeros #(
        .WIDTH (WIDTH)
    ) u_clz (
        .i_word  (word_sel),
        .o_count (clz_count),
        .o_zero  (clz_zero)
    );

    // Advance the pointer past the requester that just transferred.
    always_comb begin
        ptr_d = ptr_q;
        if (xfer) begin
            ptr_d = (gnt_idx == IW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    // Result register next state: load on transfer, drain on consume, else hold.
    always_comb begin
        res_valid_d = res_valid_q;
        res_count_d = res_count_q;
        res_zero_d  = res_zero_q;
        res_id_d    = res_id_q;
        if (xfer) begin
            res_valid_d = 1'b1;
            res_count_d = clz_count;
            res_zero_d  = clz_zero;
            res_id_d    = gnt_idx;
        end else if (bus.i_RES_READY) begin
            res_valid_d = 1'b0;
        end
    end

    // State registers; reset discards any held result and restarts at requester 0.
    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            ptr_q       <= '0;
            res_valid_q <= 1'b0;
            res_count_q <= '0;
            res_zero_q  <= 1'b0;
            res_id_q    <= '0;
        end else begin
            ptr_q       <= ptr_d;
            res_valid_q <= res_valid_d;
            res_count_q <= res_count_d;
            res_zero_q  <= res_zero_d;
            res_id_q    <= res_id_d;
        end
    end

    assign bus.o_RES_VALID = res_valid_q;
    assign bus.o_RES_COUNT = res_count_q;
    assign bus.o_RES_ZERO  = res_zero_q;
    assign bus.o_RES_ID    = res_id_q;

endmodule

// File: tb/tb_clz_arbiter.sv
// Directed bench for clz_arbiter: reset, single request, wrap/skip,
// fairness, CLZ boundaries, backpressure and asynchronous reset.
module tb_clz_arbiter;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    clz_arbiter_if #(.NUM_REQ(4), .WIDTH(32)) bus ();

    clz_arbiter #(
        .NUM_REQ (4),
        .WIDTH   (32)
    ) dut (
        .i_CLK   (clk),
        .i_RST_N (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_word(input int k, input logic [31:0] w);
        bus.i_REQ_WORD[k*32 +: 32] = w;
    endtask

    task automatic check_res(input string tag, input logic v, input logic [5:0] c,
                             input logic z, input logic [1:0] id);
        check({tag, "_valid"}, 64'(bus.o_RES_VALID), 64'(v));
        check({tag, "_count"}, 64'(bus.o_RES_COUNT), 64'(c));
        check({tag, "_zero"},  64'(bus.o_RES_ZERO),  64'(z));
        check({tag, "_id"},    64'(bus.o_RES_ID),    64'(id));
    endtask

    logic [1:0] fair_id;
    logic [5:0] fair_cnt [4];

    initial begin
        tests = 0;
        fails = 0;
        fair_cnt[0] = 6'd20;
        fair_cnt[1] = 6'd9;
        fair_cnt[2] = 6'd30;
        fair_cnt[3] = 6'd1;

        // Reset held with every requester valid: no grant, outputs cleared.
        rst_n           = 1'b0;
        bus.i_REQ_VALID = 4'b1111;
        bus.i_REQ_WORD  = '0;
        bus.i_RES_READY = 1'b0;
        #2;
        check("rst_ready", 64'(bus.o_REQ_READY), 64'h0);
        check_res("rst", 1'b0, 6'd0, 1'b0, 2'd0);
        bus.i_REQ_VALID = 4'b0000;
        #10;
        rst_n = 1'b1;
        #1;

        // Single request from requester 2.
        bus.i_REQ_VALID = 4'b0100;
        set_word(2, 32'h0000_8228);
        bus.i_RES_READY = 1'b1;
        #1;
        check("single_ready", 64'(bus.o_REQ_READY), 64'b0100);
        tick();
        check_res("single", 1'b1, 6'd16, 1'b0, 2'd2);

        // Pointer at 3, only requester 1 valid: wraps and skips to 1.
        bus.i_REQ_VALID = 4'b0010;
        set_word(1, 32'h0001_0000);
        #1;
        check("wrap_ready", 64'(bus.o_REQ_READY), 64'b0010);
        tick();
        check_res("wrap", 1'b1, 6'd15, 1'b0, 2'd1);

        // Pointer now 2: with 0,1,3 valid, requester 3 wins.
        bus.i_REQ_VALID = 4'b1011;
        set_word(0, 32'h0000_0F00);
        set_word(3, 32'h4000_0000);
        #1;
        check("ptr2_ready", 64'(bus.o_REQ_READY), 64'b1000);
        tick();
        check_res("ptr2", 1'b1, 6'd1, 1'b0, 2'd3);

        // Fairness: all valid, pointer at 0, grants 0,1,2,3,0,1 back to back.
        set_word(0, 32'h0000_0F00);
        set_word(1, 32'h0040_0000);
        set_word(2, 32'h0000_0003);
        set_word(3, 32'h4000_0000);
        bus.i_REQ_VALID = 4'b1111;
        for (int n = 0; n < 6; n++) begin
            fair_id = 2'(n % 4);
            #1;
            check("fair_ready", 64'(bus.o_REQ_READY), 64'(4'b0001 << fair_id));
            tick();
            check_res("fair", 1'b1, fair_cnt[fair_id], 1'b0, fair_id);
        end

        // CLZ boundaries from requester 0 on consecutive cycles.
        bus.i_REQ_VALID = 4'b0001;
        set_word(0, 32'h0000_0000);
        #1;
        check("bnd0_ready", 64'(bus.o_REQ_READY), 64'b0001);
        tick();
        check_res("bnd_zero", 1'b1, 6'd32, 1'b1, 2'd0);
        set_word(0, 32'h8000_0000);
        #1;
        check("bnd1_ready", 64'(bus.o_REQ_READY), 64'b0001);
        tick();
        check_res("bnd_msb", 1'b1, 6'd0, 1'b0, 2'd0);
        set_word(0, 32'h0000_0001);
        tick();
        check_res("bnd_lsb", 1'b1, 6'd31, 1'b0, 2'd0);

        // Backpressure: result held, no grants for five cycles.
        bus.i_REQ_VALID = 4'b0100;
        set_word(2, 32'h0000_0100);
        bus.i_RES_READY = 1'b0;
        for (int n = 0; n < 5; n++) begin
            #1;
            check("bp_ready", 64'(bus.o_REQ_READY), 64'h0);
            tick();
            check_res("bp_hold", 1'b1, 6'd31, 1'b0, 2'd0);
        end
        bus.i_RES_READY = 1'b1;
        #1;
        check("bp_release_ready", 64'(bus.o_REQ_READY), 64'b0100);
        tick();
        check_res("bp_release", 1'b1, 6'd23, 1'b0, 2'd2);

        // Asynchronous reset between edges while a result is held.
        bus.i_REQ_VALID = 4'b0000;
        bus.i_RES_READY = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_res("arst", 1'b0, 6'd0, 1'b0, 2'd0);
        bus.i_REQ_VALID = 4'b1001;
        set_word(0, 32'h0000_FFFF);
        set_word(3, 32'h0008_0000);
        #1;
        check("arst_ready", 64'(bus.o_REQ_READY), 64'h0);
        bus.i_RES_READY = 1'b1;
        #1;
        rst_n = 1'b1;
        #1;
        check("post_rst_ready0", 64'(bus.o_REQ_READY), 64'b0001);
        tick();
        check_res("post_rst0", 1'b1, 6'd16, 1'b0, 2'd0);
        #1;
        check("post_rst_ready3", 64'(bus.o_REQ_READY), 64'b1000);
        tick();
        check_res("post_rst3", 1'b1, 6'd12, 1'b0, 2'd3);

        // Drain: no new transfer, consumer ready, valid clears.
        bus.i_REQ_VALID = 4'b0000;
        tick();
        check("drain_valid", 64'(bus.o_RES_VALID), 64'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/clz_arbiter.md
Name: clz_arbiter

Overview:
- Shares a single count_leading_zeros datapath between NUM_REQ independent requesters.
- Arbitration is round-robin, and each requester has its own valid/ready handshake.
- Result is registered and tagged with the requester ID, and respects downstream backpressure.
- Sits in front of normalisation and priority-encode consumers that each lack their own CLZ.

Parameters:
- NUM_REQ, 4, number of requesters; must be ≥2.
- WIDTH, 32, operand width; must be a power of two and ≥2.

Ports:
- i_CLK  in  1  clock; all state updates on rising edge.
- i_RST_N  in  1  asynchronous active-low reset.
- i_REQ_VALID  in  NUM_REQ  per-requester operand valid.
- i_REQ_WORD  in  NUM_REQ*WIDTH  operands; requester k occupies bits [k*WIDTH +: WIDTH].
- o_REQ_READY  out  NUM_REQ  one-hot grant; a transfer occurs when valid and ready are both high.
- o_RES_VALID  out  1  result register holds a result.
- o_RES_COUNT  out  $clog2(WIDTH)+1  leading-zero count, range 0..WIDTH.
- o_RES_ZERO  out  1  operand was all zeros (count == WIDTH).
- o_RES_ID  out  max(1,$clog2(NUM_REQ))  index of the requester that produced the result.
- i_RES_READY  in  1  downstream accepts the result.

Behaviour:
- Reset (asynchronous assert, synchronous deassert at the consumer side):
  - o_RES_VALID=0, o_RES_COUNT=0, o_RES_ZERO=0, o_RES_ID=0.
  - Round-robin pointer=0, so requester 0 has highest priority.
  - o_REQ_READY=0 while i_RST_N is low.
- Capacity: at most one grant per cycle. can_accept = !o_RES_VALID | i_RES_READY.
- Grant:
  - If can_accept, o_REQ_READY is one-hot to the first valid requester searching from the pointer upward, wrapping mod NUM_REQ.
  - Otherwise o_REQ_READY is all zeros.
  - o_REQ_READY depends combinationally on i_REQ_VALID, the pointer, o_RES_VALID and i_RES_READY. No ready-to-valid loop exists inside the block.
- Pointer: on the edge where requester g transfers, pointer <= (g+1) mod NUM_REQ. It is unchanged when no transfer occurs.
- Latency:
  - Operand transferred at edge k appears on o_RES_* after edge k (one cycle), with o_RES_VALID=1.
  - Back-to-back throughput is 1 result/cycle while i_RES_READY=1.
- Result register:
  - Loads on transfer.
  - Clears o_RES_VALID when i_RES_READY=1 and no new transfer occurs.
  - Holds all o_RES_* stable while o_RES_VALID=1 and i_RES_READY=0.
- Simultaneous events: consume plus new grant in the same cycle means the register reloads and o_RES_VALID stays 1, with no bubble.
- Arithmetic:
  - count = number of zero bits above the most significant 1 of the operand.
  - Operand 0 gives count=WIDTH and o_RES_ZERO=1.
  - Operand with the MSB set gives count=0.
- Requester rules:
  - Requesters hold WORD stable while VALID is high and unacknowledged.
  - The block never grants a requester whose VALID is low.
- Reset mid-operation discards any held result. Pending requests are re-arbitrated from pointer 0 after reset releases.
- Fairness: with all requesters continuously valid and i_RES_READY=1, grants cycle 0,1,2,3,0,… Any valid requester waits at most NUM_REQ-1 grants.

Decomposition:
- Package clz_pkg holds:
  - CLZ_WIDTH default (32).
  - Functions cnt_w(width)=$clog2(width)+1 and id_w(n)=max(1,$clog2(n)).
- Sub-module: instantiate the existing count_leading_zeros on the muxed granted operand; its output feeds the result register.
- Round-robin selection is inline. Implement it as a double-width masked priority search, not a separate module.

Test Plan:
- Single request: after reset, req 2 valid with 0x00008228 and i_RES_READY=1 → ready[2] in the same cycle; next cycle o_RES_VALID=1, COUNT=16, ZERO=0, ID=2; pointer=3.
- Boundaries: operands 0x00000000, 0x80000000, 0x00000001 from req 0 → COUNT 32/ZERO=1, 0/0, 31/0 on consecutive cycles, with no bubbles.
- Fairness: all 4 valid continuously with distinct words → ID sequence 0,1,2,3,0,1 and one result per cycle.
- Backpressure: hold i_RES_READY=0 for 5 cycles with result held → o_REQ_READY=0 and o_RES_* unchanged. Raise ready → stall releases and the next grant occurs in the same cycle.
- Wrap and skip: pointer=3 with only req 1 valid → grant req 1 and pointer becomes 2.
- Async reset mid-stream: drop i_RST_N between edges while o_RES_VALID=1 → outputs go to 0 immediately. After release, req 3 and req 0 both valid → req 0 granted first.
